// File: rtl/iob_ram_rd_stream_pkg.sv
// Shared definitions for the RAM read streamer: FSM encodings and FIFO sizing.
package iob_ram_rd_stream_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned FifoCntW  = 2;
  localparam logic [FifoCntW-1:0] FifoFull = FifoCntW'(FifoDepth);

endpackage

// File: rtl/iob_skid_fifo2.sv
// Two-entry FIFO holding RAM read data between the RAM port and the output stream.
module iob_skid_fifo2
  import iob_ram_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [DATA_W-1:0]   din_i,
  input  logic                pop_i,
  output logic                valid_o,
  output logic [DATA_W-1:0]   dout_o,
  output logic [FifoCntW-1:0] count_o
);

  logic [DATA_W-1:0]   mem_q [FifoDepth];
  logic                rd_ptr_q, wr_ptr_q;
  logic [FifoCntW-1:0] count_q, count_d;
  logic                do_pop, do_push;

  assign valid_o = (count_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != FifoFull) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + FifoCntW'(1);
      2'b01:   count_d = count_q - FifoCntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_q ^ do_push;
      rd_ptr_q <= rd_ptr_q ^ do_pop;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/iob_tdp_ram.sv
// True dual-port RAM with registered, read-first outputs on both ports.
module iob_tdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_din_i,
  output logic [DATA_W-1:0] a_dout_o,
  input  logic              b_en_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_din_i,
  output logic [DATA_W-1:0] b_dout_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      if (a_we_i) mem[a_addr_i] <= a_din_i;
      a_dout_o <= mem[a_addr_i];
    end
    if (b_en_i) begin
      if (b_we_i) mem[b_addr_i] <= b_din_i;
      b_dout_o <= mem[b_addr_i];
    end
  end

endmodule

// File: rtl/iob_ram_rd_stream.sv
// Reads a strided burst of words from a RAM port and presents them as a valid/ready stream.
module iob_ram_rd_stream
  import iob_ram_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  localparam int unsigned LEN_W = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam logic [FifoCntW:0] OccLim = (FifoCntW + 1)'(FifoDepth);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]    len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic                rd_pend_q;
  logic                accept, issue, pop, last_pop, fifo_valid;
  logic [FifoCntW-1:0] fifo_cnt;
  logic [FifoCntW:0]   occ;

  assign accept   = (state_q == StIdle) && start;
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && m_last;
  // Words held plus the read on the RAM output; a pop this cycle frees one slot.
  assign occ      = {1'b0, fifo_cnt} + {{FifoCntW{1'b0}}, rd_pend_q};
  assign issue    = (state_q == StRun) && (issued_q < len_q) &&
                    ((occ < OccLim) || (pop && (occ == OccLim)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len == '0) ? StDone : StRun;
      StRun:   if (last_pop) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    ram_en = issue;
  end

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    if (accept) begin
      addr_d   = base;
      stride_d = stride;
      len_d    = len;
      issued_d = '0;
      popped_d = '0;
    end else begin
      if (issue) begin
        addr_d   = addr_q + stride_q;
        issued_d = issued_q + LEN_W'(1);
      end
      if (pop) popped_d = popped_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      popped_q  <= popped_d;
      rd_pend_q <= issue;
    end
  end

  iob_skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rd_pend_q),
    .din_i   (ram_dout),
    .pop_i   (m_ready),
    .valid_o (fifo_valid),
    .dout_o  (m_data),
    .count_o (fifo_cnt)
  );

  assign m_valid  = fifo_valid;
  assign m_last   = fifo_valid && (popped_q == len_q - LEN_W'(1));
  assign ram_addr = addr_q;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;

endmodule

// File: tb/tb_iob_ram_rd_stream.sv
// Directed bench for iob_ram_rd_stream driving a dual-port RAM preloaded with RAM[i] = i + 0x100.
module tb_iob_ram_rd_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [LEN_W-1:0]  len;
    int                rdy_pct;
    bit                restart;
    int                exp_valid_cyc;
    int                exp_done_cyc;
    logic [DATA_W-1:0] exp_first;
    logic [DATA_W-1:0] exp_last;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, start, m_ready;
  logic [ADDR_W-1:0] base, stride;
  logic [LEN_W-1:0]  len;
  logic              busy, done, ram_en, ram_we, m_valid, m_last;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout, m_data;
  logic              b_en, b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din, b_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_ram_rd_stream #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .stride   (stride),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  iob_tdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i    (clk),
    .a_en_i   (ram_en),
    .a_we_i   (ram_we),
    .a_addr_i (ram_addr),
    .a_din_i  (ram_din),
    .a_dout_o (ram_dout),
    .b_en_i   (b_en),
    .b_we_i   (b_we),
    .b_addr_i (b_addr),
    .b_din_i  (b_din),
    .b_dout_o (b_dout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  // Runs one burst; cycle numbers count negedges after the one that raised start.
  task automatic run_burst(input vec_t v, input int idx);
    int                n_iss = 0;
    int                n_pop = 0;
    int                budget;
    bit                finished = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] a;
    string             p;
    p = $sformatf("v%0d", idx);
    budget = 4 * int'(v.len) + 40;
    @(negedge clk);
    start = 1'b1; base = v.base; stride = v.stride; len = v.len;
    #1;
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      start = v.restart && (cyc == 2);
      if (start) begin
        base = 10'd500; stride = 10'd5; len = 11'd3;
      end else begin
        base = v.base; stride = v.stride; len = v.len;
      end
      m_ready = ($urandom_range(99) < v.rdy_pct);
      #1;
      if (prev_stall) begin
        chk({p, "_stall_valid"}, m_valid, 1);
        chk({p, "_stall_data"}, m_data, prev_data);
      end
      if (ram_en) begin
        a = v.base + ADDR_W'(n_iss) * v.stride;
        chk({p, "_issue_count"}, n_iss < int'(v.len), 1);
        chk({p, "_ram_addr"}, ram_addr, a);
        chk({p, "_issue_gate"}, (n_iss - n_pop - int'(m_valid && m_ready)) >= 2, 0);
        n_iss++;
      end
      chk({p, "_m_last"}, m_last, m_valid && (n_pop == int'(v.len) - 1));
      if (m_valid) chk({p, "_extra_word"}, n_pop < int'(v.len), 1);
      if (m_valid && m_ready) begin
        a = v.base + ADDR_W'(n_pop) * v.stride;
        if (n_pop == 0 && v.exp_valid_cyc >= 0) chk({p, "_first_valid_cyc"}, cyc, v.exp_valid_cyc);
        if (n_pop == 0) chk({p, "_first_data"}, m_data, v.exp_first);
        if (n_pop == int'(v.len) - 1) chk({p, "_last_data"}, m_data, v.exp_last);
        chk({p, "_m_data"}, m_data, {{(DATA_W - ADDR_W){1'b0}}, a} + 32'h100);
        n_pop++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        finished = 1;
        chk({p, "_words_popped"}, n_pop, v.len);
        chk({p, "_words_issued"}, n_iss, v.len);
        chk({p, "_busy_in_done"}, busy, 1);
        if (v.exp_done_cyc >= 0) chk({p, "_done_cyc"}, cyc, v.exp_done_cyc);
      end
    end
    if (!finished) chk({p, "_done_timeout"}, 0, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({p, "_busy_after"}, busy, 0);
    chk({p, "_done_after"}, done, 0);
    chk({p, "_ram_en_after"}, ram_en, 0);
  endtask

  vec_t vecs[7];
  vec_t v_fresh;
  int   n;

  initial begin
    vecs[0] = '{10'd4,    10'd1, 11'd4,    100, 1'b0,  3,    7, 32'h104, 32'h107};
    vecs[1] = '{10'd1022, 10'd1, 11'd4,    100, 1'b0,  3,    7, 32'h4FE, 32'h101};
    vecs[2] = '{10'd0,    10'd3, 11'd8,     50, 1'b0, -1,   -1, 32'h100, 32'h115};
    vecs[3] = '{10'd0,    10'd0, 11'd0,    100, 1'b0, -1,    1, 32'h0,   32'h0};
    vecs[4] = '{10'd100,  10'd2, 11'd6,    100, 1'b1,  3,    9, 32'h164, 32'h16E};
    vecs[5] = '{10'd1000, 10'd7, 11'd5,     30, 1'b0, -1,   -1, 32'h4E8, 32'h104};
    vecs[6] = '{10'd0,    10'd1, 11'd1024, 100, 1'b0,  3, 1027, 32'h100, 32'h4FF};
    v_fresh = '{10'd0,    10'd1, 11'd2,    100, 1'b0,  3,    5, 32'h100, 32'h101};

    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    base = '0; stride = '0; len = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;

    for (int i = 0; i < 2**ADDR_W; i++) begin
      @(negedge clk);
      b_en = 1'b1; b_we = 1'b1; b_addr = ADDR_W'(i); b_din = 32'h100 + 32'(i);
    end
    @(negedge clk);
    b_en = 1'b0; b_we = 1'b0;
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

    // Start held into the DONE cycle of an empty burst must not launch another one.
    @(negedge clk);
    start = 1'b1; base = 10'd7; len = 11'd0; m_ready = 1'b1;
    #1;
    @(negedge clk);
    len = 11'd5;
    #1;
    chk("done_cycle_done", done, 1);
    chk("done_cycle_busy", busy, 1);
    chk("done_cycle_ram_en", ram_en, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_in_done_ignored", busy, 0);
    chk("start_in_done_ram_en", ram_en, 0);
    @(negedge clk);
    #1;
    chk("start_in_done_idle", busy, 0);
    chk("start_in_done_m_valid", m_valid, 0);

    // Reset in the middle of a long burst, then a fresh short burst.
    @(negedge clk);
    start = 1'b1; base = 10'd8; stride = 10'd1; len = 11'd16; m_ready = 1'b1;
    #1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_valid && m_ready) n++;
    end
    chk("midburst_three_words", n, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midburst_rst");
    @(negedge clk);
    rst = 1'b0;
    run_burst(v_fresh, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
